fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage that sits directly upstream of instr_mem.
//  Holds the PC and drives the word address into the asynchronous instruction memory.
//  Registers the returned instruction into an IF/ID output register with a valid/ready handshake to decode.
//  Accepts taken-branch/jump redirects from execute and flushes the in-flight instruction.
// PARAMETERS
//  XLEN          32            datapath/PC width
//  RESET_VECTOR  32'h0000_0000 PC value after reset
//  NOP_INSTR     32'h0000_0013 value of out_instr while invalid (addi x0,x0,0)
// PORTS
//  clk             in   1     rising-edge clock
//  rst             in   1     synchronous, active-high reset
//  fetch_en        in   1     1 = fetch permitted; 0 = freeze PC, issue nothing new
//  redirect_valid  in   1     execute requests PC change this cycle
//  redirect_pc     in   XLEN  redirect target
//  imem_addr       out  XLEN  byte address to instr_mem (combinational = pc_q)
//  imem_rdata      in   XLEN  instruction word from instr_mem (same-cycle read)
//  out_valid       out  1     IF/ID register holds a live instruction
//  out_ready       in   1     decode accepts out_* this cycle
//  out_instr       out  XLEN  fetched instruction
//  out_pc          out  XLEN  address of out_instr
//  out_pc_plus4    out  XLEN  out_pc + 4 (mod 2^XLEN)
//  fetch_fault     out  1     misaligned redirect detected (only with FETCH_MISALIGN_TRAP_EN)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): pc_q<=RESET_VECTOR; out_valid<=0; out_instr<=NOP_INSTR;
//    out_pc<=0; out_pc_plus4<=0; fetch_fault<=0. Reset overrides all other inputs,
//    including a mid-stall or mid-redirect state.
//  - imem_addr = {pc_q[XLEN-1:2],2'b00}, purely combinational.
//  - load = fetch_en & (~out_valid | out_ready). Priority: rst > redirect > load > hold.
//  - Redirect cycle: pc_q<=redirect_pc with [1:0] forced to 00; out_valid<=0.
//    The current fetch is discarded regardless of out_ready or fetch_en.
//    The target appears at out_valid=1 two cycles after the redirect cycle (penalty 1 bubble).
//  - Load cycle (no redirect): out_instr<=imem_rdata; out_pc<=pc_q; out_pc_plus4<=pc_q+4;
//    out_valid<=1; pc_q<=pc_q+4.
//  - Stall (out_valid & ~out_ready): all out_* and pc_q hold; out_* stable until accepted.
//  - fetch_en=0: pc_q holds. If out_ready, out_valid<=0 and out_instr<=NOP_INSTR; otherwise out_* hold.
//  - Simultaneous redirect and stall: the redirect wins and the held instruction is dropped.
//  - PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, with no flag.
//  - Steady-state throughput is 1 instruction/cycle with out_ready=1.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined:
//   - A redirect with redirect_pc[1:0]!=0 sets fetch_fault<=1 and an internal halted flag.
//   - While halted, load is suppressed and out_valid<=0 on accept.
//   - Both fault and halt clear on the next aligned redirect or on rst.
//  FETCH_MISALIGN_TRAP_EN undefined:
//   - The low bits of redirect_pc are silently forced to 00.
//   - fetch_fault is tied to 0 (port still present).
// STRUCTURE
//  - Package riscv_pkg: XLEN, NOP_INSTR constant, RESET_VECTOR default, and typedef
//    struct packed {instr, pc, pc_plus4} if_id_t used for the output register.
//  - One sub-module, fetch_pc_gen: pc_q register, +4 adder, redirect mux,
//    misalign check. The top level holds the IF/ID register and handshake.
// TESTING
//  1. Reset then out_ready=1, fetch_en=1 for 4 cycles, imem returns 0xA0+addr ->
//     out_pc=0,4,8 consecutively, one per cycle; out_valid low only in the first cycle after reset.
//  2. Stall: out_ready=0 for 3 cycles while out_pc=8 -> out_pc/out_instr hold at 8;
//     imem_addr stays 0xC; resuming gives out_pc=0xC next.
//  3. Redirect to 0x100 while out_valid=1 and out_ready=0 -> the next cycle has out_valid=0;
//     the following cycle has out_pc=0x100 and out_pc_plus4=0x104.
//  4. Redirect to 0xFFFF_FFFC -> out_pc=0xFFFF_FFFC, then out_pc=0x0 with out_pc_plus4=0x4.
//  5. fetch_en=0 with out_ready=1 -> out_valid drops after one accept and pc_q is frozen;
//     rst asserted mid-stall -> pc=RESET_VECTOR and out_valid=0 the next cycle.
//  6. (macro on) Redirect to 0x102 -> fetch_fault=1, no valid output;
//     redirect to 0x200 -> fault clears and out_pc=0x200 two cycles later.
//     (macro off) Redirect to 0x102 -> fetch_fault stays 0 and out_pc=0x100.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and the IF/ID register layout for the fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// PC register with +4 increment and redirect mux; misaligned-redirect trap when
// FETCH_MISALIGN_TRAP_EN is defined.
module fetch_pc_gen
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fault,
    output logic            halted
);

    logic [XLEN-1:0] target;

    assign target   = word_align(redirect_pc);
    assign pc_plus4 = pc_q + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else if (redirect_valid) begin
            pc_q <= target;
        end else if (advance) begin
            pc_q <= pc_plus4;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    logic fault_q;

    assign misaligned = redirect_pc != target;

    // Fault and halt share one flag: both set on a bad target, both clear on a good one.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= misaligned;
        end
    end

    assign fault  = fault_q;
    assign halted = fault_q;
`else
    assign fault  = 1'b0;
    assign halted = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives instr_mem and holds the IF/ID register with a
// valid/ready handshake. Optional macro: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic            fetch_fault
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic            halted;
    logic            load;
    logic            valid_q;
    if_id_t          if_id_q;

    assign load = fetch_en & ~halted & (~valid_q | out_ready);

    // Redirect takes priority over load inside the PC generator as well.
    fetch_pc_gen #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc_gen (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .advance       (load),
        .pc_q          (pc_q),
        .pc_plus4      (pc_plus4),
        .fault         (fetch_fault),
        .halted        (halted)
    );

    assign imem_addr = word_align(pc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q          <= 1'b0;
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.pc       <= '0;
            if_id_q.pc_plus4 <= '0;
        end else if (redirect_valid) begin
            valid_q       <= 1'b0;
            if_id_q.instr <= NOP_INSTR;
        end else if (load) begin
            valid_q          <= 1'b1;
            if_id_q.instr    <= imem_rdata;
            if_id_q.pc       <= pc_q;
            if_id_q.pc_plus4 <= pc_plus4;
        end else if (out_ready) begin
            // Accepted with nothing new to issue (fetch disabled or halted).
            valid_q       <= 1'b0;
            if_id_q.instr <= NOP_INSTR;
        end
    end

    assign out_valid    = valid_q;
    assign out_instr    = if_id_q.instr;
    assign out_pc       = if_id_q.pc;
    assign out_pc_plus4 = if_id_q.pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instr_mem is modelled as rdata = 0xA0 + addr.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'h0000_00A0 + imem_addr;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc_plus4  (out_pc_plus4),
        .fetch_fault   (fetch_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] instr);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".instr"}, out_instr, instr);
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        step();
        // 1. reset state and streaming
        rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        check_out("rst", 1'b0, 32'h0, 32'h13);
        check("rst.plus4", out_pc_plus4, 32'h0);
        check("rst.addr", imem_addr, 32'h0);
        check("rst.fault", 32'(fetch_fault), 32'h0);
        step(); check_out("s0", 1'b1, 32'h0, 32'hA0); check("s0.plus4", out_pc_plus4, 32'h4);
        step(); check_out("s1", 1'b1, 32'h4, 32'hA4);
        step(); check_out("s2", 1'b1, 32'h8, 32'hA8); check("s2.addr", imem_addr, 32'hC);

        // 2. stall holds everything
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall", 1'b1, 32'h8, 32'hA8);
            check("stall.addr", imem_addr, 32'hC);
        end
        out_ready = 1'b1;
        step(); check_out("resume", 1'b1, 32'hC, 32'hAC);

        // 3. redirect during stall drops the held instruction
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step(); redirect_valid = 1'b0; out_ready = 1'b1;
        check("redir.valid", 32'(out_valid), 32'h0);
        check("redir.addr", imem_addr, 32'h100);
        step(); check_out("redir.tgt", 1'b1, 32'h100, 32'h1A0);
        check("redir.plus4", out_pc_plus4, 32'h104);

        // 4. PC wraps modulo 2^32
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); redirect_valid = 1'b0;
        check("wrap.bubble", 32'(out_valid), 32'h0);
        step(); check_out("wrap.top", 1'b1, 32'hFFFF_FFFC, 32'h0000_009C);
        check("wrap.top.plus4", out_pc_plus4, 32'h0);
        step(); check_out("wrap.zero", 1'b1, 32'h0, 32'hA0);
        check("wrap.zero.plus4", out_pc_plus4, 32'h4);

        // 5. fetch disabled, then reset in the middle of a stall
        fetch_en = 1'b0;
        step(); check_out("fen0.a", 1'b0, 32'h0, 32'h13); check("fen0.a.addr", imem_addr, 32'h4);
        step(); check("fen0.b.valid", 32'(out_valid), 32'h0); check("fen0.b.addr", imem_addr, 32'h4);
        fetch_en = 1'b1; out_ready = 1'b0;
        step(); check_out("fen1", 1'b1, 32'h4, 32'hA4);
        step(); check_out("hold", 1'b1, 32'h4, 32'hA4); check("hold.addr", imem_addr, 32'h8);
        rst = 1'b1;
        step(); rst = 1'b0; out_ready = 1'b1;
        check_out("midrst", 1'b0, 32'h0, 32'h13);
        check("midrst.addr", imem_addr, 32'h0);

        // 6. misaligned redirect
        step(); check_out("pre6", 1'b1, 32'h0, 32'hA0);
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step(); redirect_valid = 1'b0;
        check("mis.valid", 32'(out_valid), 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis.fault", 32'(fetch_fault), 32'h1);
        step(); check("halt.valid", 32'(out_valid), 32'h0); check("halt.fault", 32'(fetch_fault), 32'h1);
        step(); check("halt2.valid", 32'(out_valid), 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(); redirect_valid = 1'b0;
        check("clr.fault", 32'(fetch_fault), 32'h0); check("clr.valid", 32'(out_valid), 32'h0);
        step(); check_out("clr.tgt", 1'b1, 32'h200, 32'h2A0);
`else
        check("mis.fault", 32'(fetch_fault), 32'h0);
        step(); check_out("mis.tgt", 1'b1, 32'h100, 32'h1A0);
        check("mis.fault2", 32'(fetch_fault), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
